// File: rtl/ser_arb_pkg.sv
// ser_arb_pkg: FSM state type and default word/count widths shared with the serializer
package ser_arb_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int MOD_W_DEF = 4;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} arb_state_t;
endpackage

// File: rtl/ser_arb_rr_pick.sv
// ser_arb_rr_pick: combinational round-robin pick of the first valid requester after last_grant
module ser_arb_rr_pick
  import ser_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  // scan farthest-to-nearest so the nearest valid index after last_grant is the one left in idx
  always_comb begin
    idx = '0;
    for (int k = N_REQ; k >= 1; k--)
      if (req[(int'(last_grant) + k) % N_REQ]) idx = IDX_W'((int'(last_grant) + k) % N_REQ);
  end
  assign any = |req;
  assign gnt = any ? (N_REQ'(1) << idx) : '0;
endmodule

// File: rtl/ser_arbiter.sv
// ser_arbiter: round-robin arbiter feeding one word at a time to a shared serializer (optional SER_ARB_STATS_EN adds words_sent_o)
module ser_arbiter
  import ser_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int MOD_W = MOD_W_DEF,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic                    clk_i,
  input  logic                    srst_i,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  input  logic [N_REQ*MOD_W-1:0]  req_mod_i,
  input  logic [N_REQ-1:0]        req_val_i,
  output logic [N_REQ-1:0]        req_rdy_o,
  output logic [DATA_W-1:0]       ser_data_o,
  output logic [MOD_W-1:0]        ser_mod_o,
  output logic                    ser_val_o,
  input  logic                    ser_busy_i,
  output logic [IDX_W-1:0]        grant_id_o,
  output logic                    busy_o
`ifdef SER_ARB_STATS_EN
  ,
  output logic [31:0]             words_sent_o
`endif
);
  arb_state_t state;
  logic [IDX_W-1:0] last_grant;
  logic [N_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0] pick_idx;
  logic pick_any;
  logic can_grant;
  ser_arb_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req(req_val_i),
    .last_grant(last_grant),
    .gnt(pick_gnt),
    .idx(pick_idx),
    .any(pick_any)
  );
  // grants only open in IDLE with a free serializer and never while reset is held
  assign can_grant = (state == IDLE) && !ser_busy_i && !srst_i;
  assign req_rdy_o = can_grant ? pick_gnt : '0;
  assign busy_o = state != IDLE;
  // latch the winner, strobe the serializer once, then hold the word until it finishes
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state <= IDLE;
      last_grant <= IDX_W'(N_REQ - 1);
      ser_val_o <= 1'b0;
      ser_data_o <= '0;
      ser_mod_o <= '0;
      grant_id_o <= '0;
    end else begin
      case (state)
        IDLE: if (can_grant && pick_any) begin
          ser_data_o <= req_data_i[pick_idx*DATA_W +: DATA_W];
          ser_mod_o <= req_mod_i[pick_idx*MOD_W +: MOD_W];
          grant_id_o <= pick_idx;
          last_grant <= pick_idx;
          ser_val_o <= 1'b1;
          state <= LAUNCH;
        end
        LAUNCH: begin
          ser_val_o <= 1'b0;
          state <= WAIT;
        end
        WAIT: if (!ser_busy_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef SER_ARB_STATS_EN
  // count serializer launches, wrapping naturally at 2^32
  always_ff @(posedge clk_i) words_sent_o <= srst_i ? '0 : words_sent_o + 32'(state == LAUNCH);
`endif
endmodule

// File: tb/tb_ser_arbiter.sv
// tb_ser_arbiter: directed and randomized checks of ser_arbiter against a transfer-level model
module tb_ser_arbiter;
  localparam int N = 4, DW = 16, MW = 4, IW = 2;
  logic clk_i = 1'b0;
  logic srst_i;
  logic [N*DW-1:0] req_data_i;
  logic [N*MW-1:0] req_mod_i;
  logic [N-1:0] req_val_i, req_rdy_o;
  logic [DW-1:0] ser_data_o;
  logic [MW-1:0] ser_mod_o;
  logic ser_val_o, ser_busy_i, busy_o, force_busy;
  logic [IW-1:0] grant_id_o;
`ifdef SER_ARB_STATS_EN
  logic [31:0] words_sent_o;
`endif
  int n_chk = 0, n_fail = 0;
  ser_arbiter #(.N_REQ(N), .DATA_W(DW), .MOD_W(MW)) dut (
    .clk_i(clk_i),
    .srst_i(srst_i),
    .req_data_i(req_data_i),
    .req_mod_i(req_mod_i),
    .req_val_i(req_val_i),
    .req_rdy_o(req_rdy_o),
    .ser_data_o(ser_data_o),
    .ser_mod_o(ser_mod_o),
    .ser_val_o(ser_val_o),
    .ser_busy_i(ser_busy_i),
    .grant_id_o(grant_id_o),
    .busy_o(busy_o)
`ifdef SER_ARB_STATS_EN
    ,
    .words_sent_o(words_sent_o)
`endif
  );
  always #5 clk_i = ~clk_i;
  // serializer stand-in: busy for exactly the word's bit count after each start strobe
  int scnt = 0;
  assign ser_busy_i = (scnt != 0) || force_busy;
  always @(posedge clk_i)
    if (srst_i) scnt <= 0;
    else if (ser_val_o) scnt <= (ser_mod_o == '0) ? DW : int'(ser_mod_o);
    else if (scnt != 0) scnt <= scnt - 1;
  // transfer-level reference: owner active from accept until the first non-busy cycle two or more cycles later
  logic m_act = 1'b0;
  int m_age = 0, m_last = N - 1, m_gid = 0, m_launches = 0, m_win;
  logic [DW-1:0] m_data = '0;
  logic [MW-1:0] m_mod = '0;
  logic [N-1:0] exp_rdy;
  always_comb begin
    m_win = -1;
    for (int k = 1; k <= N; k++)
      if (m_win < 0 && req_val_i[(m_last + k) % N]) m_win = (m_last + k) % N;
    exp_rdy = (!m_act && !ser_busy_i && !srst_i && m_win >= 0) ? (N'(1) << m_win) : '0;
  end
  always @(posedge clk_i) begin
    if (srst_i) begin
      m_act <= 1'b0; m_last <= N - 1; m_gid <= 0; m_data <= '0; m_mod <= '0; m_launches <= 0;
    end else if (m_act) begin
      if (m_age >= 2 && !ser_busy_i) m_act <= 1'b0;
      if (m_age == 1) m_launches <= m_launches + 1;
      m_age <= m_age + 1;
    end else if (exp_rdy != '0) begin
      m_act <= 1'b1; m_age <= 1; m_last <= m_win; m_gid <= m_win;
      m_data <= req_data_i[m_win*DW +: DW];
      m_mod <= req_mod_i[m_win*MW +: MW];
    end
  end
  task automatic drive();
    @(posedge clk_i);
    #1;
  endtask
  task automatic wait_idle(output bit ok);
    for (int c = 0; c < 80 && busy_o; c++) @(negedge clk_i);
    ok = !busy_o;
  endtask
  task automatic test_reset();
    bit ok;
    drive(); srst_i = 1'b1; req_val_i = '1;
    @(negedge clk_i);
    n_chk++;
    if (req_rdy_o !== '0) begin n_fail++; $display("FAIL reset_rdy_during_srst: got %b want 0000", req_rdy_o); end
    drive(); srst_i = 1'b0; req_val_i = '0;
    @(negedge clk_i);
    n_chk++;
    if ({ser_val_o, ser_data_o, ser_mod_o, grant_id_o, busy_o, req_rdy_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: val %b data %h mod %h gid %0d busy %b rdy %b want all 0", ser_val_o, ser_data_o, ser_mod_o, grant_id_o, busy_o, req_rdy_o);
    end
    wait_idle(ok);
  endtask
  task automatic test_single();
    int waits = 0;
    drive(); req_data_i = '0; req_data_i[DW-1:0] = 16'hA5C3; req_mod_i = '0; req_val_i = 4'b0001;
    @(negedge clk_i);
    n_chk++;
    if (req_rdy_o !== 4'b0001) begin n_fail++; $display("FAIL single_rdy: got %b want 0001", req_rdy_o); end
    drive(); req_val_i = '0; req_data_i = '0;
    @(negedge clk_i);
    n_chk++;
    if (ser_val_o !== 1'b1 || ser_data_o !== 16'hA5C3 || grant_id_o !== 2'd0) begin
      n_fail++; $display("FAIL single_launch: val %b data %h gid %0d want 1 a5c3 0", ser_val_o, ser_data_o, grant_id_o);
    end
    do begin
      @(negedge clk_i);
      waits++;
      if (busy_o) begin
        n_chk++;
        if (ser_data_o !== 16'hA5C3 || ser_val_o !== 1'b0) begin
          n_fail++; $display("FAIL single_hold: data %h val %b want a5c3 0", ser_data_o, ser_val_o);
        end
      end
    end while (busy_o && waits < 60);
    n_chk++;
    if (waits !== 18) begin n_fail++; $display("FAIL single_wait_len: got %0d cycles want 18", waits); end
  endtask
  task automatic test_rotate();
    int got[$], at[$], pend = -1;
    bit ok;
    drive(); srst_i = 1'b1; req_val_i = '1;
    for (int i = 0; i < N; i++) begin
      req_data_i[i*DW +: DW] = DW'(16'h1000 + i);
      req_mod_i[i*MW +: MW] = MW'(4);
    end
    drive(); srst_i = 1'b0;
    for (int c = 0; c < 100 && got.size() < 5; c++) begin
      @(negedge clk_i);
      if (pend >= 0) begin
        n_chk++;
        if (ser_val_o !== 1'b1 || grant_id_o !== IW'(pend) || ser_data_o !== DW'(16'h1000 + pend)) begin
          n_fail++; $display("FAIL rotate_launch: val %b gid %0d data %h want 1 %0d %h", ser_val_o, grant_id_o, ser_data_o, pend, 16'h1000 + pend);
        end
        pend = -1;
      end
      for (int i = 0; i < N; i++) if (req_rdy_o[i]) begin got.push_back(i); at.push_back(c); pend = i; end
    end
    drive(); req_val_i = '0;
    n_chk++;
    if (got.size() != 5) begin n_fail++; $display("FAIL rotate_count: got %0d grants want 5", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      n_chk++;
      if (got[i] != i % N) begin n_fail++; $display("FAIL rotate_order[%0d]: got %0d want %0d", i, got[i], i % N); end
      if (i > 0) begin
        n_chk++;
        if (at[i] - at[i-1] != 7) begin n_fail++; $display("FAIL rotate_spacing[%0d]: got %0d want 7", i, at[i] - at[i-1]); end
      end
    end
    wait_idle(ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL rotate_idle: busy_o stuck at %b want 0", busy_o); end
  endtask
  task automatic test_busy_block();
    bit ok;
    drive(); force_busy = 1'b1; req_val_i = '1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      n_chk++;
      if (req_rdy_o !== '0) begin n_fail++; $display("FAIL busy_block_rdy: got %b want 0000", req_rdy_o); end
    end
    drive(); force_busy = 1'b0;
    @(negedge clk_i);
    n_chk++;
    if (req_rdy_o !== 4'b0010) begin n_fail++; $display("FAIL busy_release_rdy: got %b want 0010", req_rdy_o); end
    drive(); req_val_i = '0;
    wait_idle(ok);
  endtask
  task automatic test_reset_wait();
    int b = 0;
    bit ok;
    drive(); req_mod_i = '0; req_val_i = 4'b1000;
    @(negedge clk_i);
    n_chk++;
    if (req_rdy_o !== 4'b1000) begin n_fail++; $display("FAIL rstwait_rdy: got %b want 1000", req_rdy_o); end
    for (int c = 0; c < 30 && b < 5; c++) begin
      drive(); req_val_i = '0;
      if (ser_busy_i) b++;
    end
    srst_i = 1'b1; req_val_i = '1;
    @(negedge clk_i);
    n_chk++;
    if (busy_o !== 1'b1 || req_rdy_o !== '0) begin
      n_fail++; $display("FAIL rstwait_in_wait: busy %b rdy %b want 1 0000", busy_o, req_rdy_o);
    end
    drive(); srst_i = 1'b0;
    @(negedge clk_i);
    n_chk++;
    if ({ser_val_o, ser_data_o, ser_mod_o, grant_id_o, busy_o} !== '0 || req_rdy_o !== 4'b0001) begin
      n_fail++;
      $display("FAIL rstwait_after: val %b data %h mod %h gid %0d busy %b rdy %b want 0 0 0 0 0 0001", ser_val_o, ser_data_o, ser_mod_o, grant_id_o, busy_o, req_rdy_o);
    end
    drive(); req_val_i = '0;
    wait_idle(ok);
  endtask
  task automatic test_back_to_back();
    int at[$];
    bit ok;
    drive(); req_mod_i[2*MW +: MW] = MW'(5); req_val_i = 4'b0100;
    for (int c = 0; c < 60 && at.size() < 3; c++) begin
      @(negedge clk_i);
      if (req_rdy_o != '0) begin
        at.push_back(c);
        n_chk++;
        if (req_rdy_o !== 4'b0100) begin n_fail++; $display("FAIL b2b_rdy: got %b want 0100", req_rdy_o); end
      end
    end
    drive(); req_val_i = '0;
    n_chk++;
    if (at.size() != 3) begin n_fail++; $display("FAIL b2b_count: got %0d grants want 3", at.size()); end
    for (int i = 1; i < at.size(); i++) begin
      n_chk++;
      if (at[i] - at[i-1] != 8) begin n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d want 8", i, at[i] - at[i-1]); end
    end
    wait_idle(ok);
  endtask
`ifdef SER_ARB_STATS_EN
  task automatic test_stats();
    int acc = 0;
    bit ok;
    drive(); srst_i = 1'b1;
    for (int i = 0; i < N; i++) req_mod_i[i*MW +: MW] = MW'(1);
    drive(); srst_i = 1'b0; req_val_i = '1;
    for (int c = 0; c < 200 && acc < 10; c++) begin
      @(negedge clk_i);
      if (req_rdy_o != '0) acc++;
    end
    drive(); req_val_i = '0;
    wait_idle(ok);
    n_chk++;
    if (words_sent_o !== 32'd10) begin n_fail++; $display("FAIL stats_words: got %0d want 10", words_sent_o); end
  endtask
`endif
  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      drive();
      srst_i = ($urandom_range(63) == 0);
      force_busy = ($urandom_range(9) == 0);
      req_val_i = N'($urandom) & N'($urandom);
      for (int i = 0; i < N; i++) begin
        req_data_i[i*DW +: DW] = DW'($urandom);
        req_mod_i[i*MW +: MW] = MW'($urandom);
      end
      @(negedge clk_i);
      n_chk++;
      if (req_rdy_o !== exp_rdy || ser_val_o !== (m_act && m_age == 1) || busy_o !== m_act ||
          ser_data_o !== m_data || ser_mod_o !== m_mod || grant_id_o !== IW'(m_gid)) begin
        n_fail++;
        $display("FAIL random[%0d]: rdy %b/%b val %b/%b busy %b/%b data %h/%h mod %h/%h gid %0d/%0d", c,
                 req_rdy_o, exp_rdy, ser_val_o, m_act && m_age == 1, busy_o, m_act, ser_data_o, m_data, ser_mod_o, m_mod, grant_id_o, m_gid);
      end
`ifdef SER_ARB_STATS_EN
      n_chk++;
      if (words_sent_o !== 32'(m_launches)) begin n_fail++; $display("FAIL random_words[%0d]: got %0d want %0d", c, words_sent_o, m_launches); end
`endif
    end
  endtask
  initial begin
    srst_i = 1'b1; force_busy = 1'b0; req_val_i = '0; req_data_i = '0; req_mod_i = '0;
    test_reset();
    test_single();
    test_rotate();
    test_busy_block();
    test_reset_wait();
    test_back_to_back();
`ifdef SER_ARB_STATS_EN
    test_stats();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t want finished", $time);
    $fatal(1);
  end
endmodule

// File: doc/ser_arbiter.md
SER_ARBITER -- requirements
Module: ser_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter DATA_W, default 16, SHALL set the word width presented to the serializer.
REQ-003 Parameter MOD_W, default 4, SHALL set the bit-count field width; value 0 means DATA_W bits.
REQ-004 clk_i  in  1  SHALL be the single clock; all logic on its rising edge.
REQ-005 srst_i  in  1  SHALL be the synchronous, active-high reset.
REQ-006 req_data_i  in  N_REQ*DATA_W  SHALL carry the per-requester words, requester i at slice i.
REQ-007 req_mod_i  in  N_REQ*MOD_W  SHALL carry the per-requester bit counts.
REQ-008 req_val_i  in  N_REQ  SHALL carry the per-requester valid bits.
REQ-009 req_rdy_o  out  N_REQ  SHALL carry the per-requester accept bits; transfer when val&rdy.
REQ-010 ser_data_o  out  DATA_W  SHALL drive the serializer data input.
REQ-011 ser_mod_o  out  MOD_W  SHALL drive the serializer bit-count input.
REQ-012 ser_val_o  out  1  SHALL drive the serializer start strobe.
REQ-013 ser_busy_i  in  1  SHALL be the serializer busy flag.
REQ-014 grant_id_o  out  $clog2(N_REQ)  SHALL give the index of the requester currently owning the serializer.
REQ-015 busy_o  out  1  SHALL be high whenever the FSM is not in IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, LAUNCH and WAIT.
REQ-017 In IDLE with ser_busy_i low and any req_val_i high, exactly one req_rdy_o bit SHALL be high (combinational), chosen round-robin starting at last_grant+1, modulo N_REQ.
REQ-018 req_rdy_o SHALL be all-zero outside IDLE, and in IDLE while ser_busy_i is high.
REQ-019 On an accept edge, the block SHALL latch the winner's data, mod and index into holding registers and go to LAUNCH; last_grant SHALL take the winner index.
REQ-020 In LAUNCH, ser_val_o SHALL be high for exactly one cycle; next state WAIT.
REQ-021 In WAIT, the block SHALL return to IDLE on the first cycle ser_busy_i is low.
REQ-022 A new grant SHALL be possible in that same IDLE cycle, giving a minimum accept-to-accept spacing of 3 + serial length cycles.
REQ-023 ser_data_o, ser_mod_o and grant_id_o SHALL be driven from the holding registers and stay stable from LAUNCH through WAIT, because the serializer reads data bits throughout the transfer.
REQ-024 A requester dropping req_val_i after acceptance SHALL NOT affect the transfer in flight.
REQ-025 With a single active requester, it SHALL be granted back-to-back with no fairness gap.
REQ-026 With all requesters active, grants SHALL rotate through every index in strict order, with no index granted twice before all others.

Reset
REQ-027 srst_i SHALL take effect at any state, including mid-WAIT, and put the FSM in IDLE.
REQ-028 Reset values SHALL be: ser_val_o 0, ser_data_o 0, ser_mod_o 0, grant_id_o 0, req_rdy_o 0, busy_o 0, last_grant N_REQ-1 (requester 0 wins first).
REQ-029 req_rdy_o SHALL be 0 during any cycle in which srst_i is high.

Configuration
REQ-030 Macro SER_ARB_STATS_EN defined: the block SHALL add output words_sent_o [31:0], which counts LAUNCH cycles, resets to 0 and wraps at 2^32.
REQ-031 Macro SER_ARB_STATS_EN undefined: the port and counter SHALL be absent, with no other behavioural difference.

Structure
REQ-032 Package ser_arb_pkg SHALL hold the FSM state enum and default DATA_W/MOD_W constants; the serializer is shared with the package constants.
REQ-033 Sub-module ser_arb_rr_pick SHALL be the combinational round-robin picker (req vector + last_grant -> one-hot grant + index + any flag).

Verification
REQ-034 Reset then req_val_i=4'b0001, data 16'hA5C3, mod 0 -> rdy[0] same cycle, ser_val_o one cycle later, ser_data_o=16'hA5C3 held until ser_busy_i falls.
REQ-035 All four valid continuously, mod 4 -> grant order 0,1,2,3,0 with each LAUNCH following the previous WAIT exit.
REQ-036 ser_busy_i forced high in IDLE with req_val_i=4'b1111 -> req_rdy_o stays 0 until busy falls.
REQ-037 srst_i asserted in WAIT on the 5th busy cycle -> next cycle all outputs at reset values, and the next grant goes to requester 0.
REQ-038 Only requester 2 valid, 3 words -> three grants to index 2, accept-to-accept spacing equal to 3 + serial length cycles.
REQ-039 With SER_ARB_STATS_EN defined, 10 completed words -> words_sent_o=10; without the macro the bench compiles with no such port.
